// File: rtl/demod_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : demod_cfg_sequencer
//  Description : Configuration sequencer for one quadrature_demod channel.
//                Validates a requested config, holds the demod in reset while
//                the config is applied, discards CIC settling samples and
//                forwards only post-settle samples downstream.
//                Optional watchdog/auto-resync: define DEMOD_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module demod_cfg_sequencer #(
    parameter int ADC_WIDTH      = 14,
    parameter int NCO_RESOLUTION = 16,
    parameter int OUT_WIDTH      = 16,
    parameter int R_MAX          = 3000,
    parameter int RESET_CYCLES   = 16,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      apply_i,
    input  logic [NCO_RESOLUTION-1:0] phi_inc_i,
    input  logic [15:0]               decimation_i,
    input  logic [15:0]               cic_comp_i,
    input  logic [ADC_WIDTH-1:0]      offset_i,
    output logic                      demod_reset_o,
    output logic [NCO_RESOLUTION-1:0] phi_inc_o,
    output logic [15:0]               decimation_o,
    output logic [15:0]               cic_comp_o,
    output logic [ADC_WIDTH-1:0]      offset_o,
    input  logic                      demod_valid_i,
    input  logic [OUT_WIDTH-1:0]      demod_data_i,
    output logic [OUT_WIDTH-1:0]      data_o,
    output logic                      data_valid_o,
    output logic                      busy_o,
    output logic                      locked_o,
    output logic                      cfg_err_o,
    output logic                      timeout_o
);

    localparam int FW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [FW-1:0] c_flush_last  = FW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] c_settle_last = SW'(SETTLE_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        FLUSH  = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4
    } state_t;

    state_t                    r_state, w_next;
    state_t                    r_ret, w_ret_next;
    logic                      r_pending;
    logic [FW-1:0]             r_flush_cnt;
    logic [SW-1:0]             r_settle_cnt;
    logic [NCO_RESOLUTION-1:0] r_sh_phi;
    logic [15:0]               r_sh_dec;
    logic [15:0]               r_sh_cic;
    logic [ADC_WIDTH-1:0]      r_sh_off;
    logic                      w_bad, w_accept, w_reject, w_clr_pending, w_fwd;
    logic                      w_pend_any, w_wdog_hit;

    // Shadow decimation is illegal when zero or above the supported maximum
    assign w_bad      = (r_sh_dec == 16'd0) || (r_sh_dec > 16'(R_MAX));
    // A request arriving on the very cycle of a transition counts as pending
    assign w_pend_any = r_pending | apply_i;

    assign demod_reset_o = (r_state == IDLE) || (r_state == FLUSH);
    assign busy_o        = (r_state == CHECK) || (r_state == FLUSH) || (r_state == SETTLE);
    assign locked_o      = (r_state == RUN);

    // State and return-state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ret   <= IDLE;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret_next;
        end
    end

    // Next-state decode and per-cycle strobes
    always_comb begin
        w_next        = r_state;
        w_ret_next    = r_ret;
        w_accept      = 1'b0;
        w_reject      = 1'b0;
        w_clr_pending = 1'b0;
        case (r_state)
            IDLE: begin
                if (apply_i) begin
                    w_next     = CHECK;
                    w_ret_next = IDLE;
                end
            end
            CHECK: begin
                if (w_bad) begin
                    w_reject = 1'b1;
                    if (w_pend_any) begin
                        // a newer request is queued: evaluate it next cycle
                        w_next        = CHECK;
                        w_clr_pending = 1'b1;
                    end else begin
                        w_next = r_ret;
                    end
                end else begin
                    w_accept = 1'b1;
                    w_next   = FLUSH;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == c_flush_last) begin
                    if (w_pend_any) begin
                        // a rejected follow-up re-runs the applied config
                        w_next        = CHECK;
                        w_ret_next    = FLUSH;
                        w_clr_pending = 1'b1;
                    end else begin
                        w_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (demod_valid_i && (r_settle_cnt == c_settle_last)) begin
                    if (w_pend_any) begin
                        w_next        = CHECK;
                        w_ret_next    = FLUSH;
                        w_clr_pending = 1'b1;
                    end else begin
                        w_next = RUN;
                    end
                end else if (w_wdog_hit) begin
                    w_next = FLUSH;
                end
            end
            RUN: begin
                if (apply_i) begin
                    w_next     = CHECK;
                    w_ret_next = RUN;
                end else if (w_wdog_hit) begin
                    w_next = FLUSH;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Samples are forwarded in RUN and across a rejected check that returns to RUN
    assign w_fwd = (r_state == RUN) ||
                   ((r_state == CHECK) && w_reject && (w_next == RUN));

    // Pending flag, shadow registers and sticky config error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_sh_phi  <= '0;
            r_sh_dec  <= '0;
            r_sh_cic  <= '0;
            r_sh_off  <= '0;
            cfg_err_o <= 1'b0;
        end else begin
            if (apply_i) begin
                r_sh_phi <= phi_inc_i;
                r_sh_dec <= decimation_i;
                r_sh_cic <= cic_comp_i;
                r_sh_off <= offset_i;
            end
            if (w_clr_pending)
                r_pending <= 1'b0;
            else if (apply_i && busy_o)
                r_pending <= 1'b1;
            if (w_reject)
                cfg_err_o <= 1'b1;
            else if (w_accept)
                cfg_err_o <= 1'b0;
        end
    end

    // Applied config only changes on the edge that enters FLUSH
    always_ff @(posedge clk) begin
        if (reset) begin
            phi_inc_o    <= '0;
            decimation_o <= '0;
            cic_comp_o   <= '0;
            offset_o     <= '0;
        end else if (w_accept) begin
            phi_inc_o    <= r_sh_phi;
            decimation_o <= r_sh_dec;
            cic_comp_o   <= r_sh_cic;
            offset_o     <= r_sh_off;
        end
    end

    // Saturating FLUSH cycle counter and SETTLE pulse counter
    always_ff @(posedge clk) begin
        if (reset || (r_state != FLUSH))
            r_flush_cnt <= '0;
        else if (r_flush_cnt != c_flush_last)
            r_flush_cnt <= r_flush_cnt + 1'b1;
        if (reset || (r_state != SETTLE))
            r_settle_cnt <= '0;
        else if (demod_valid_i && (r_settle_cnt != c_settle_last))
            r_settle_cnt <= r_settle_cnt + 1'b1;
    end

    // Downstream sample register: 1-cycle latency, data held between strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_valid_o <= w_fwd & demod_valid_i;
            if (w_fwd && demod_valid_i)
                data_o <= demod_data_i;
        end
    end

`ifdef DEMOD_WDOG_EN
    logic [16:0] r_wdog_cnt;
    logic [16:0] w_wdog_limit;
    logic        w_wdog_active;

    assign w_wdog_active = (r_state == SETTLE) || (r_state == RUN);
    assign w_wdog_limit  = {decimation_o, 1'b0} + 17'(RESET_CYCLES);
    assign w_wdog_hit    = w_wdog_active && !demod_valid_i &&
                           ((r_wdog_cnt + 17'd1) >= w_wdog_limit);

    // Idle-cycle watchdog; sticky timeout cleared by reset or accepted apply
    always_ff @(posedge clk) begin
        if (reset || !w_wdog_active || demod_valid_i || w_wdog_hit)
            r_wdog_cnt <= '0;
        else if (r_wdog_cnt != 17'h1FFFF)
            r_wdog_cnt <= r_wdog_cnt + 17'd1;
        if (reset || w_accept)
            timeout_o <= 1'b0;
        else if (w_wdog_hit)
            timeout_o <= 1'b1;
    end
`else
    assign w_wdog_hit = 1'b0;
    assign timeout_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demod_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demod_cfg_sequencer
//  Description : Directed self-checking bench for demod_cfg_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demod_cfg_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        apply_i = 1'b0;
    logic [15:0] phi_inc_i = '0;
    logic [15:0] decimation_i = '0;
    logic [15:0] cic_comp_i = '0;
    logic [13:0] offset_i = '0;
    logic        demod_reset_o;
    logic [15:0] phi_inc_o;
    logic [15:0] decimation_o;
    logic [15:0] cic_comp_o;
    logic [13:0] offset_o;
    logic        demod_valid_i = 1'b0;
    logic [15:0] demod_data_i = '0;
    logic [15:0] data_o;
    logic        data_valid_o;
    logic        busy_o;
    logic        locked_o;
    logic        cfg_err_o;
    logic        timeout_o;

    int n_pass  = 0;
    int n_total = 0;
    int n;
    logic seen_valid = 1'b0;

    demod_cfg_sequencer dut (
        .clk(clk), .reset(reset), .apply_i(apply_i),
        .phi_inc_i(phi_inc_i), .decimation_i(decimation_i),
        .cic_comp_i(cic_comp_i), .offset_i(offset_i),
        .demod_reset_o(demod_reset_o), .phi_inc_o(phi_inc_o),
        .decimation_o(decimation_o), .cic_comp_o(cic_comp_o),
        .offset_o(offset_o), .demod_valid_i(demod_valid_i),
        .demod_data_i(demod_data_i), .data_o(data_o),
        .data_valid_o(data_valid_o), .busy_o(busy_o), .locked_o(locked_o),
        .cfg_err_o(cfg_err_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Sticky record of any forwarded strobe
    always @(negedge clk) if (data_valid_o) seen_valid = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_apply(input logic [15:0] phi, input logic [15:0] dec,
                            input logic v, input logic [15:0] d);
        apply_i = 1'b1; phi_inc_i = phi; decimation_i = dec;
        cic_comp_i = dec ^ 16'h00FF; offset_i = 14'(phi + 16'd3);
        demod_valid_i = v; demod_data_i = d;
        tick();
        apply_i = 1'b0; demod_valid_i = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] d);
        demod_valid_i = 1'b1; demod_data_i = d;
        tick();
        demod_valid_i = 1'b0;
    endtask

    // Counts cycles with demod_reset_o high, bounded
    task automatic wait_low(output int cnt);
        cnt = 0;
        while (demod_reset_o && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        // ---------------- reset state
        tick(); tick(); tick();
        chk("rst_demod_reset", demod_reset_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_cfg_err", cfg_err_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_phi", phi_inc_o, 0);
        chk("rst_dec", decimation_o, 0);
        chk("rst_dvalid", data_valid_o, 0);
        reset = 1'b0;
        tick();

        // ---------------- 1: first apply and settle
        do_apply(16, 2000, 0, 0);
        chk("t1_busy", busy_o, 1);
        tick();
        chk("t1_phi", phi_inc_o, 16);
        chk("t1_dec", decimation_o, 2000);
        chk("t1_cic", cic_comp_o, 2000 ^ 16'h00FF);
        chk("t1_off", offset_o, 19);
        wait_low(n);
        chk("t1_flush_len", n, 16);
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse(16'h0100 + 16'(i));
            tick();
        end
        chk("t1_settle_silent", seen_valid, 0);
        chk("t1_locked", locked_o, 1);
        chk("t1_busy_off", busy_o, 0);
        pulse(16'h1234);
        chk("t1_fwd_valid", data_valid_o, 1);
        chk("t1_fwd_data", data_o, 16'h1234);
        tick();
        chk("t1_valid_drop", data_valid_o, 0);
        chk("t1_data_hold", data_o, 16'h1234);

        // ---------------- 2: rejected requests from RUN
        do_apply(99, 3001, 0, 0);
        chk("t2_check_busy", busy_o, 1);
        pulse(16'h2222);
        chk("t2_err", cfg_err_o, 1);
        chk("t2_locked", locked_o, 1);
        chk("t2_stream_valid", data_valid_o, 1);
        chk("t2_stream_data", data_o, 16'h2222);
        chk("t2_dec_kept", decimation_o, 2000);
        chk("t2_phi_kept", phi_inc_o, 16);
        do_apply(5, 0, 0, 0);
        tick();
        chk("t2_err0", cfg_err_o, 1);
        chk("t2_locked0", locked_o, 1);
        chk("t2_dec_kept0", decimation_o, 2000);

        // ---------------- 3: second apply during FLUSH
        do_apply(16, 100, 1, 16'h5A5A);
        chk("t3_apply_fwd_valid", data_valid_o, 1);
        chk("t3_apply_fwd_data", data_o, 16'h5A5A);
        tick();
        chk("t3_err_cleared", cfg_err_o, 0);
        chk("t3_phi_first", phi_inc_o, 16);
        seen_valid = 1'b0;
        tick(); tick(); tick();
        do_apply(32, 200, 0, 0);
        wait_low(n);
        chk("t3_flush_rest", n, 12);
        chk("t3_recheck_busy", busy_o, 1);
        chk("t3_recheck_phi_old", phi_inc_o, 16);
        tick();
        chk("t3_phi_second", phi_inc_o, 32);
        chk("t3_dec_second", decimation_o, 200);
        wait_low(n);
        chk("t3_flush2_len", n, 16);
        for (int i = 0; i < 4; i++) begin
            pulse(16'h0300 + 16'(i));
            tick();
        end
        chk("t3_silent", seen_valid, 0);
        chk("t3_locked", locked_o, 1);

        // ---------------- 4: reset during SETTLE, then reject from IDLE
        do_apply(16, 2000, 0, 0);
        tick();
        wait_low(n);
        pulse(16'h0401); tick();
        pulse(16'h0402);
        reset = 1'b1;
        tick();
        chk("t4_demod_reset", demod_reset_o, 1);
        chk("t4_busy", busy_o, 0);
        chk("t4_locked", locked_o, 0);
        chk("t4_err", cfg_err_o, 0);
        chk("t4_dvalid", data_valid_o, 0);
        reset = 1'b0;
        tick();
        do_apply(1, 0, 0, 0);
        tick();
        chk("t4_idle_err", cfg_err_o, 1);
        chk("t4_idle_reset", demod_reset_o, 1);
        chk("t4_idle_busy", busy_o, 0);
        chk("t4_idle_dec", decimation_o, 0);
        do_apply(16, 2000, 0, 0);
        tick();
        wait_low(n);
        for (int i = 0; i < 3; i++) begin
            pulse(16'h0410 + 16'(i));
            tick();
        end
        chk("t4_not_yet_locked", locked_o, 0);
        pulse(16'h0413);
        chk("t4_locked", locked_o, 1);
        chk("t4_err_cleared", cfg_err_o, 0);

        // ---------------- 5: spaced stream forwarded with 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            repeat (10) tick();
            pulse(16'h8000 + 16'(i) * 16'h1111);
            chk("t5_valid", data_valid_o, 1);
            chk("t5_data", data_o, 16'h8000 + 16'(i) * 16'h1111);
            tick();
            chk("t5_gap", data_valid_o, 0);
        end

        // ---------------- 6: stalled stream in RUN
        repeat (4100) tick();
`ifdef DEMOD_WDOG_EN
        chk("t6_timeout", timeout_o, 1);
        chk("t6_resync", locked_o, 0);
`else
        chk("t6_timeout", timeout_o, 0);
        chk("t6_still_run", locked_o, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
